// File: rtl/hash_key_feeder.sv
// -----------------------------------------------------------------------------
// hash_key_feeder
//
// Transmitter front-end for the pipelined Jenkins hash. The host writes one key
// (up to MAXLEN bytes) into a local buffer; the key is then streamed one byte
// per cycle on char/charcnt, where charcnt is the count of bytes remaining
// including the current one (0 when nothing is being streamed). A fixed number
// of cycles after the stream ends, the hash result is captured into key_out and
// announced with a one-cycle key_valid strobe.
//
// Ports:
//   CLK           clock, all logic on the rising edge
//   RST           asynchronous active-high reset
//   wr_en         host byte-write strobe
//   wr_data[7:0]  key byte
//   wr_last       final byte of the key (qualified by wr_en)
//   wr_ready      high while a write would be accepted (IDLE/LOAD)
//   char[7:0]     key byte presented to the hash
//   charcnt[7:0]  remaining bytes including the current one, 0 when idle
//   hashkey[31:0] result from the hash block
//   key_out[31:0] captured hash, held until the next capture
//   key_valid     one-cycle pulse when key_out is updated
//   busy          high while streaming or waiting for the hash
//   err_overflow  one-cycle pulse when a key exceeds MAXLEN bytes
// -----------------------------------------------------------------------------
module hash_key_feeder #(
    parameter int MAXLEN       = 250,
    parameter int HASH_LATENCY = 24
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        wr_last,
    output logic        wr_ready,
    output logic [7:0]  char,
    output logic [7:0]  charcnt,
    input  logic [31:0] hashkey,
    output logic [31:0] key_out,
    output logic        key_valid,
    output logic        busy,
    output logic        err_overflow
);

    localparam int LAT_W = $clog2(HASH_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_WAIT
    } state_t;

    // Registered state and outputs
    state_t             r_state;
    logic [7:0]         r_len;
    logic [7:0]         r_idx;
    logic [LAT_W-1:0]   r_lat;
    logic [7:0]         r_char;
    logic [7:0]         r_charcnt;
    logic [31:0]        r_key_out;
    logic               r_key_valid;
    logic               r_busy;
    logic               r_wr_ready;
    logic               r_err_overflow;
    logic [7:0]         r_buf [MAXLEN];

    // Next-state values
    state_t             w_state_nxt;
    logic [7:0]         w_len_nxt;
    logic [7:0]         w_idx_nxt;
    logic [LAT_W-1:0]   w_lat_nxt;
    logic [7:0]         w_char_nxt;
    logic [7:0]         w_charcnt_nxt;
    logic [31:0]        w_key_out_nxt;
    logic               w_key_valid_nxt;
    logic               w_err_nxt;
    logic               w_buf_we;
    logic [7:0]         w_buf_waddr;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned; a missing default here would infer a latch.
        w_state_nxt     = r_state;
        w_len_nxt       = r_len;
        w_idx_nxt       = r_idx;
        w_lat_nxt       = r_lat;
        w_char_nxt      = r_char;
        w_charcnt_nxt   = r_charcnt;
        w_key_out_nxt   = r_key_out;
        w_key_valid_nxt = 1'b0;
        w_err_nxt       = 1'b0;
        w_buf_we        = 1'b0;
        w_buf_waddr     = r_len;

        case (r_state)
            S_IDLE: begin
                if (wr_en) begin
                    w_buf_we    = 1'b1;
                    w_buf_waddr = 8'd0;
                    w_len_nxt   = 8'd1;
                    if (wr_last) begin
                        // Byte 0 is being written this cycle, so forward it
                        // straight to char instead of reading the buffer.
                        w_state_nxt   = S_STREAM;
                        w_idx_nxt     = 8'd0;
                        w_charcnt_nxt = 8'd1;
                        w_char_nxt    = wr_data;
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                if (wr_en) begin
                    if (r_len == 8'(MAXLEN)) begin
                        // Key too long: drop the byte and the whole key.
                        w_err_nxt   = 1'b1;
                        w_len_nxt   = 8'd0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_buf_we  = 1'b1;
                        w_len_nxt = r_len + 8'd1;
                        if (wr_last) begin
                            w_state_nxt   = S_STREAM;
                            w_idx_nxt     = 8'd0;
                            w_charcnt_nxt = r_len + 8'd1;
                            w_char_nxt    = r_buf[0];
                        end
                    end
                end
            end

            S_STREAM: begin
                if (r_charcnt > 8'd1) begin
                    w_idx_nxt     = r_idx + 8'd1;
                    w_char_nxt    = r_buf[r_idx + 8'd1];
                    w_charcnt_nxt = r_charcnt - 8'd1;
                end else begin
                    // First charcnt==0 cycle is latency count 1.
                    w_charcnt_nxt = 8'd0;
                    w_char_nxt    = 8'd0;
                    w_lat_nxt     = LAT_W'(1);
                    w_state_nxt   = S_WAIT;
                end
            end

            S_WAIT: begin
                if (r_lat == LAT_W'(HASH_LATENCY)) begin
                    w_key_out_nxt   = hashkey;
                    w_key_valid_nxt = 1'b1;
                    w_len_nxt       = 8'd0;
                    w_state_nxt     = S_IDLE;
                end else begin
                    w_lat_nxt = r_lat + LAT_W'(1);
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state        <= S_IDLE;
            r_len          <= 8'd0;
            r_idx          <= 8'd0;
            r_lat          <= '0;
            r_char         <= 8'd0;
            r_charcnt      <= 8'd0;
            r_key_out      <= 32'd0;
            r_key_valid    <= 1'b0;
            r_busy         <= 1'b0;
            r_wr_ready     <= 1'b1;
            r_err_overflow <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_len          <= w_len_nxt;
            r_idx          <= w_idx_nxt;
            r_lat          <= w_lat_nxt;
            r_char         <= w_char_nxt;
            r_charcnt      <= w_charcnt_nxt;
            r_key_out      <= w_key_out_nxt;
            r_key_valid    <= w_key_valid_nxt;
            r_busy         <= (w_state_nxt == S_STREAM) || (w_state_nxt == S_WAIT);
            r_wr_ready     <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_LOAD);
            r_err_overflow <= w_err_nxt;
        end
    end

    // NOTE: the key buffer has no reset; its contents are only read after
    // being written for the current key, so clearing it would buy nothing.
    always_ff @(posedge CLK) begin
        if (w_buf_we) begin
            r_buf[w_buf_waddr] <= wr_data;
        end
    end

    assign wr_ready     = r_wr_ready;
    assign char         = r_char;
    assign charcnt      = r_charcnt;
    assign key_out      = r_key_out;
    assign key_valid    = r_key_valid;
    assign busy         = r_busy;
    assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_hash_key_feeder.sv
// -----------------------------------------------------------------------------
// tb_hash_key_feeder
//
// Scoreboard bench for hash_key_feeder. Stimulus tasks push the expected
// stream bytes, key captures and overflow pulses (each with the cycle it must
// appear in) into a queue; a monitor on the falling edge pops and compares
// whenever the DUT shows charcnt!=0, key_valid or err_overflow.
// -----------------------------------------------------------------------------
module tb_hash_key_feeder;

    localparam int MAXLEN = 250;
    localparam int LAT    = 24;

    localparam int EV_CHAR = 0;
    localparam int EV_KEY  = 1;
    localparam int EV_OVF  = 2;

    typedef struct {
        int          kind;
        logic [31:0] data;
        logic [7:0]  cnt;
        int          cyc;
    } ev_t;

    logic        CLK;
    logic        RST;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        wr_last;
    logic        wr_ready;
    logic [7:0]  char;
    logic [7:0]  charcnt;
    logic [31:0] hashkey;
    logic [31:0] key_out;
    logic        key_valid;
    logic        busy;
    logic        err_overflow;

    ev_t         sb [$];
    logic [7:0]  key_buf [256];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [7:0]  mon_prev_cnt = 8'd0;

    hash_key_feeder #(
        .MAXLEN       (MAXLEN),
        .HASH_LATENCY (LAT)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wr_last      (wr_last),
        .wr_ready     (wr_ready),
        .char         (char),
        .charcnt      (charcnt),
        .hashkey      (hashkey),
        .key_out      (key_out),
        .key_valid    (key_valid),
        .busy         (busy),
        .err_overflow (err_overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%h, required 0x%h", name, cyc, act, exp);
        end
    endtask

    task automatic pop_expect(input int kind, input logic [31:0] data, input logic [7:0] cnt);
        ev_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_event @cycle %0d: got kind %0d data 0x%h, required no event",
                     cyc, kind, data);
        end else begin
            e = sb.pop_front();
            check("ev_kind", kind, e.kind);
            check("ev_cycle", cyc, e.cyc);
            check("ev_data", data, e.data);
            if (kind == EV_CHAR) check("ev_charcnt", {24'd0, cnt}, {24'd0, e.cnt});
        end
    endtask

    // Monitor: compares DUT output events against the scoreboard queue.
    always @(negedge CLK) begin
        if (RST) begin
            mon_prev_cnt <= 8'd0;
        end else begin
            if (mon_prev_cnt == 8'd1) begin
                check("tail_charcnt", {24'd0, charcnt}, 32'd0);
                check("tail_char", {24'd0, char}, 32'd0);
            end
            if (charcnt != 8'd0) pop_expect(EV_CHAR, {24'd0, char}, charcnt);
            if (key_valid)       pop_expect(EV_KEY, key_out, 8'd0);
            if (err_overflow)    pop_expect(EV_OVF, 32'd0, 8'd0);
            mon_prev_cnt <= charcnt;
        end
    end

    // Drive one write on the next falling edge (or right now), returning the
    // cycle number in which it is presented.
    task automatic drive(input logic [7:0] d, input logic last, input bit now, output int p);
        if (!now) @(negedge CLK);
        wr_en   = 1'b1;
        wr_data = d;
        wr_last = last;
        p       = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            wr_en   = 1'b0;
            wr_last = 1'b0;
        end
    endtask

    // Write key_buf[0..len-1], optionally with 2-cycle gaps every 'gap' bytes,
    // and queue the expected stream and capture.
    task automatic send_key(input int len, input logic [31:0] hk, input int gap,
                            input bit now, output int p);
        int pi;
        pi = 0;
        for (int i = 0; i < len; i++) begin
            drive(key_buf[i], (i == len - 1), (now && i == 0), pi);
            if (gap != 0 && i < len - 1 && (i % gap) == gap - 1) idle(2);
        end
        p       = pi;
        hashkey = hk;
        for (int k = 0; k < len; k++)
            sb.push_back('{EV_CHAR, {24'd0, key_buf[k]}, 8'(len - k), p + 1 + k});
        sb.push_back('{EV_KEY, hk, 8'd0, p + len + LAT + 1});
    endtask

    task automatic wait_kv();
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!key_valid && n < 100);
        if (!key_valid) begin
            n_cmp++;
            n_fail++;
            $display("FAIL key_valid_timeout @cycle %0d: got no key_valid in %0d cycles, required a pulse",
                     cyc, n);
        end
    endtask

    initial begin
        int p;
        int nb;
        RST     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'd0;
        wr_last = 1'b0;
        hashkey = 32'd0;

        // Reset values, sampled before the first clock edge.
        #3;
        check("rst_char", {24'd0, char}, 32'd0);
        check("rst_charcnt", {24'd0, charcnt}, 32'd0);
        check("rst_key_out", key_out, 32'd0);
        check("rst_key_valid", {31'd0, key_valid}, 32'd0);
        check("rst_err", {31'd0, err_overflow}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // wr_last without wr_en must do nothing.
        @(negedge CLK);
        wr_last = 1'b1;
        repeat (3) @(negedge CLK);
        wr_last = 1'b0;
        check("lastonly_wr_ready", {31'd0, wr_ready}, 32'd1);

        // 3-byte key "abc".
        key_buf[0] = 8'h61; key_buf[1] = 8'h62; key_buf[2] = 8'h63;
        send_key(3, 32'hA1B2_C3D4, 0, 1'b0, p);
        idle(1);
        wait_kv();
        idle(3);

        // Single byte key; busy must stay high for 1+LAT cycles.
        key_buf[0] = 8'h7A;
        send_key(1, 32'h5EED_0001, 0, 1'b0, p);
        idle(1);
        nb = 0;
        while (busy === 1'b1 && nb < 200) begin
            nb++;
            @(negedge CLK);
        end
        check("busy_cycles", nb, 1 + LAT);
        idle(3);

        // MAXLEN bytes accepted, the next one overflows.
        for (int i = 0; i < MAXLEN; i++) drive(8'(i) ^ 8'h5A, 1'b0, 1'b0, p);
        drive(8'hFF, 1'b0, 1'b0, p);
        sb.push_back('{EV_OVF, 32'd0, 8'd0, p + 1});
        idle(6);
        check("ovf_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("ovf_busy", {31'd0, busy}, 32'd0);
        check("ovf_charcnt", {24'd0, charcnt}, 32'd0);
        check("ovf_key_out", key_out, 32'h5EED_0001);

        // 13-byte key with LOAD gaps, then writes attempted during STREAM.
        for (int i = 0; i < 13; i++) key_buf[i] = 8'h41 + 8'(i);
        send_key(13, 32'h1357_9BDF, 4, 1'b0, p);
        for (int j = 0; j < 5; j++) begin
            @(negedge CLK);
            wr_en   = 1'b1;
            wr_data = 8'hEE;
            wr_last = j[0];
        end
        idle(1);
        wait_kv();
        idle(3);

        // Back-to-back: second key written in the key_valid cycle.
        key_buf[0] = 8'h11;
        send_key(1, 32'hCAFE_0011, 0, 1'b0, p);
        idle(1);
        wait_kv();
        key_buf[0] = 8'h22;
        send_key(1, 32'hBEEF_0022, 0, 1'b1, p);
        idle(1);
        wait_kv();
        idle(3);

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 5; i++) key_buf[i] = 8'hC0 + 8'(i);
        send_key(5, 32'hDEAD_BEEF, 0, 1'b0, p);
        idle(2);
        #2;
        RST = 1'b1;
        #1;
        check("abort_charcnt", {24'd0, charcnt}, 32'd0);
        check("abort_char", {24'd0, char}, 32'd0);
        check("abort_key_out", key_out, 32'd0);
        check("abort_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        sb.delete();
        @(negedge CLK);
        #1;
        RST = 1'b0;
        idle(40);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hash_key_feeder.md
Name: hash_key_feeder

Overview:
- Front-end driver for the pipelined Jenkins hash block. It is the transmitter side of the hash's byte-stream input.
- Buffers one key of up to MAXLEN bytes written by the host. It then streams the key one byte per cycle on char/charcnt, with charcnt holding the remaining-byte count.
- After a fixed pipeline latency it captures the hash's hashkey output and presents it to the host with a one-cycle valid strobe.

Parameters:
- MAXLEN, 250: maximum key length in bytes; must be ≤ 255.
- HASH_LATENCY, 24: cycles from the first charcnt==0 cycle until hashkey is sampled; must be ≥ 1.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  asynchronous, active-high reset.
- wr_en  in  1  host byte-write strobe.
- wr_data  in  8  key byte.
- wr_last  in  1  marks the final byte of the key; qualified by wr_en.
- wr_ready  out  1  high when a write is accepted this cycle.
- char  out  8  key byte to the hash.
- charcnt  out  8  remaining bytes including the current one; 0 when idle.
- hashkey  in  32  hash result from the hash block.
- key_out  out  32  captured hash; held until the next capture.
- key_valid  out  1  one-cycle pulse when key_out is updated.
- busy  out  1  high in STREAM and WAIT.
- err_overflow  out  1  one-cycle pulse when a key exceeds MAXLEN.

Behaviour:
- Reset (async, immediate), all outputs registered:
  - State goes to IDLE.
  - char=0, charcnt=0, key_out=0, key_valid=0, err_overflow=0, busy=0, wr_ready=1.
  - Length and index counters are cleared; buffer contents are don't-care.
  - Reset mid-stream takes effect immediately: charcnt drops to 0 asynchronously, and no key_valid is produced for the aborted key.
- Storage: MAXLEN x 8 buffer; write address = len, read address = idx; 8-bit counters.
- State IDLE (wr_ready=1):
  - wr_en stores wr_data at address 0 and sets len=1.
  - If wr_last is also high, go to STREAM; otherwise go to LOAD.
- State LOAD (wr_ready=1):
  - wr_en with len<MAXLEN stores the byte at address len and increments len.
  - If wr_last is also high, go to STREAM.
  - wr_en with len==MAXLEN is an overflow: byte discarded, err_overflow pulses next cycle, state returns to IDLE, key dropped.
  - Idle cycles (wr_en=0) in LOAD are permitted indefinitely.
- State STREAM (wr_ready=0, busy=1):
  - First STREAM cycle: idx=0, charcnt=len, char=buf[0].
  - Each following cycle: idx increments, charcnt decrements by 1, char=buf[idx].
  - A key of len bytes occupies exactly len cycles, charcnt running len down to 1.
  - The cycle after charcnt==1: charcnt=0, char=0, state goes to WAIT.
- State WAIT (wr_ready=0, busy=1):
  - A latency counter starts at 1 on the first charcnt==0 cycle.
  - When the counter equals HASH_LATENCY, hashkey is sampled into key_out and key_valid pulses on the following cycle.
  - The state then returns to IDLE.
- wr_en while wr_ready=0 is ignored; no error is flagged.
- wr_last without wr_en has no effect.
- Timing: the first char appears the cycle after the wr_last write is accepted. key_valid rises len+HASH_LATENCY+1 cycles after that acceptance.
- A new key may be written in the cycle key_valid is high, since the state is already IDLE.
- key_out is unchanged by overflow and by reset-free aborts; no other abort path exists.

Test Plan:
- Reset check: assert RST asynchronously mid-cycle -> char=0, charcnt=0, key_out=0, wr_ready=1 before the next edge.
- 3-byte key 0x61,0x62,0x63 (last on 3rd), hashkey driven 0xA1B2C3D4 -> charcnt 3,2,1,0 with char 0x61,0x62,0x63,0x00 on consecutive cycles; key_out=0xA1B2C3D4 with key_valid pulsed exactly 1+3+24 cycles after the wr_last acceptance.
- Single byte 0x7A with wr_last -> one cycle charcnt=1/char=0x7A, then charcnt=0; busy high for 1+24 cycles.
- MAXLEN=250 write, then 251st byte without wr_last -> err_overflow single pulse, state IDLE, charcnt stays 0, key_out unchanged.
- 13-byte key with wr_en gaps in LOAD plus writes attempted during STREAM -> charcnt 13..1 contiguous; ignored writes do not alter the stream or the buffer.
- Back-to-back: write a second 1-byte key on the key_valid cycle -> accepted, its stream begins the next cycle, and two distinct key_valid pulses are seen.
